// File: rtl/spi_slave_if.sv
// SPI slave endpoint with byte-wide parallel side. The SPI pins are
// oversampled in the i_Clk domain: nothing is clocked by the SPI clock.
// Supports all four SPI modes through SPI_MODE.
module spi_slave_if #(
    parameter int SPI_MODE = 0
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_SPI_Clk,
    output logic       o_SPI_MISO,
    input  logic       i_SPI_MOSI,
    input  logic       i_SPI_CS_n
);

    localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
    localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);

    logic       sck_meta, sck_sync, sck_prev;
    logic       cs_meta, cs_sync, cs_prev;
    logic       mosi_meta, mosi_sync;
    logic [2:0] bit_cnt;
    logic [6:0] rx_shift;
    logic [7:0] rx_next;
    logic [7:0] tx_hold;
    logic [7:0] tx_src;
    logic [6:0] tx_shift;

    logic sck_rise, sck_fall, lead_edge, trail_edge;
    logic sample_edge, shift_edge, cs_fall, cs_rise, cs_active;

    // Two-flop synchronizers plus one history flop for edge detection.
    // Idle values (SCK at CPOL, CS deasserted) keep reset from looking like an edge.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            sck_meta  <= CPOL;
            sck_sync  <= CPOL;
            sck_prev  <= CPOL;
            cs_meta   <= 1'b1;
            cs_sync   <= 1'b1;
            cs_prev   <= 1'b1;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            sck_meta  <= i_SPI_Clk;
            sck_sync  <= sck_meta;
            sck_prev  <= sck_sync;
            cs_meta   <= i_SPI_CS_n;
            cs_sync   <= cs_meta;
            cs_prev   <= cs_sync;
            mosi_meta <= i_SPI_MOSI;
            mosi_sync <= mosi_meta;
        end
    end

    assign cs_active   = ~cs_sync;
    assign cs_fall     = ~cs_sync & cs_prev;
    assign cs_rise     = cs_sync & ~cs_prev;
    assign sck_rise    = sck_sync & ~sck_prev;
    assign sck_fall    = ~sck_sync & sck_prev;
    // Leading edge leaves the idle level, trailing edge returns to it.
    assign lead_edge   = cs_active & (CPOL ? sck_fall : sck_rise);
    assign trail_edge  = cs_active & (CPOL ? sck_rise : sck_fall);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;

    assign rx_next = {rx_shift, mosi_sync};
    // A byte written in the same cycle as a load goes straight out.
    assign tx_src  = i_TX_DV ? i_TX_Byte : tx_hold;

    // RX: shift MOSI on sample edges; the 8th edge publishes the byte.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            bit_cnt   <= 3'd0;
            rx_shift  <= 7'd0;
            o_RX_Byte <= 8'h00;
            o_RX_DV   <= 1'b0;
        end else begin
            o_RX_DV <= 1'b0;
            if (cs_rise) begin
                // Partial byte is dropped; next frame restarts at bit 7.
                bit_cnt <= 3'd0;
            end else if (sample_edge) begin
                rx_shift <= rx_next[6:0];
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    o_RX_Byte <= rx_next;
                    o_RX_DV   <= 1'b1;
                end
            end
        end
    end

    // TX holding register: last write wins, survives CS release.
    always_ff @(posedge i_Clk) begin
        if (i_Rst)
            tx_hold <= 8'h00;
        else if (i_TX_DV)
            tx_hold <= i_TX_Byte;
    end

    // TX: a shift edge with the counter at 0 starts a byte (load), the
    // others present the next bit. CPHA=0 also loads on CS fall so the
    // MSB is on MISO before the first sample edge.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            tx_shift   <= 7'd0;
            o_SPI_MISO <= 1'b1;
        end else if (cs_rise) begin
            o_SPI_MISO <= 1'b1;
        end else if ((!CPHA && cs_fall) || (shift_edge && bit_cnt == 3'd0)) begin
            tx_shift   <= tx_src[6:0];
            o_SPI_MISO <= tx_src[7];
        end else if (shift_edge) begin
            o_SPI_MISO <= tx_shift[6];
            tx_shift   <= {tx_shift[5:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench: one slave instance per SPI mode, driven by a
// cycle-counted master model in the i_Clk domain.
module tb_spi_slave_if;

    localparam int H = 6;   // SCK half period in i_Clk cycles

    logic             i_Clk = 1'b0;
    logic             i_Rst = 1'b1;
    logic [3:0]       sck, cs_n, mosi, miso, rx_dv, tx_dv, tx_dv_w;
    logic [3:0][7:0]  tx_byte, tx_byte_w, rx_byte;
    logic             loop_en = 1'b0;

    int               dv_cnt [4];
    logic [7:0]       rx_log [64];
    int               n_chk = 0;
    int               n_pass = 0;

    always #5 i_Clk = ~i_Clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        assign tx_dv_w[g]   = (loop_en && g == 1) ? rx_dv[g]   : tx_dv[g];
        assign tx_byte_w[g] = (loop_en && g == 1) ? rx_byte[g] : tx_byte[g];

        spi_slave_if #(.SPI_MODE(g)) u_dut (
            .i_Clk      (i_Clk),
            .i_Rst      (i_Rst),
            .o_RX_DV    (rx_dv[g]),
            .o_RX_Byte  (rx_byte[g]),
            .i_TX_DV    (tx_dv_w[g]),
            .i_TX_Byte  (tx_byte_w[g]),
            .i_SPI_Clk  (sck[g]),
            .o_SPI_MISO (miso[g]),
            .i_SPI_MOSI (mosi[g]),
            .i_SPI_CS_n (cs_n[g])
        );

        // Count valid pulses; mode 1 also logs bytes for the loopback run.
        always @(posedge i_Clk) begin
            if (rx_dv[g]) begin
                dv_cnt[g] <= dv_cnt[g] + 1;
                if (g == 1) rx_log[dv_cnt[g] % 64] <= rx_byte[g];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge i_Clk);
    endtask

    task automatic load_tx(input int m, input logic [7:0] b);
        @(negedge i_Clk);
        tx_byte[m] = b;
        tx_dv[m]   = 1'b1;
        @(negedge i_Clk);
        tx_dv[m]   = 1'b0;
    endtask

    task automatic cs_low(input int m);
        cs_n[m] = 1'b0;
        wait_clk(8);
    endtask

    task automatic cs_high(input int m);
        wait_clk(H);
        cs_n[m] = 1'b1;
        wait_clk(8);
    endtask

    // Master: clocks nb bits of mo (MSB first), returns bits seen on MISO.
    task automatic xfer(input int m, input logic [7:0] mo, input int nb, output logic [7:0] mi);
        logic cpol, cpha;
        cpol = (m >= 2);
        cpha = (m == 1 || m == 3);
        mi = 8'h00;
        if (!cpha) mosi[m] = mo[7];
        for (int i = 7; i > 7 - nb; i--) begin
            if (!cpha) begin
                wait_clk(H);
                mi[i] = miso[m];
                sck[m] = ~cpol;
                wait_clk(H);
                sck[m] = cpol;
                if (i > 0) mosi[m] = mo[i-1];
            end else begin
                wait_clk(H);
                sck[m] = ~cpol;
                mosi[m] = mo[i];
                wait_clk(H);
                mi[i] = miso[m];
                sck[m] = cpol;
            end
        end
    endtask

    initial begin
        logic [7:0] mi;
        logic [7:0] lb_in [6];
        logic [7:0] lb_exp [6];
        int base, d0;
        logic idle_bad;

        for (int m = 0; m < 4; m++) dv_cnt[m] = 0;
        sck     = 4'b1100;      // idle at CPOL per mode
        cs_n    = 4'hF;
        mosi    = 4'h0;
        tx_dv   = 4'h0;
        tx_byte = '0;
        wait_clk(4);
        i_Rst = 1'b0;
        wait_clk(4);

        // Reset state, every mode
        for (int m = 0; m < 4; m++) begin
            chk($sformatf("rst_dv%0d", m), rx_dv[m], 1'b0);
            chk($sformatf("rst_rx%0d", m), rx_byte[m], 8'h00);
            chk($sformatf("rst_miso%0d", m), miso[m], 1'b1);
        end

        // Mode 1 single byte: 5A out, C1 in
        d0 = dv_cnt[1];
        load_tx(1, 8'h5A);
        cs_low(1);
        xfer(1, 8'hC1, 8, mi);
        cs_high(1);
        chk("m1_rx", rx_byte[1], 8'hC1);
        chk("m1_dv", dv_cnt[1] - d0, 1);
        chk("m1_miso", mi, 8'h5A);

        // Loopback, mode 1, from a fresh holding register
        i_Rst = 1'b1;
        wait_clk(2);
        i_Rst = 1'b0;
        wait_clk(4);
        loop_en = 1'b1;
        lb_in  = '{8'h00, 8'h01, 8'h80, 8'hFF, 8'h55, 8'hAA};
        lb_exp = '{8'h00, 8'h00, 8'h01, 8'h80, 8'hFF, 8'h55};
        base = dv_cnt[1];
        cs_low(1);
        for (int k = 0; k < 6; k++) begin
            xfer(1, lb_in[k], 8, mi);
            chk($sformatf("lb_miso%0d", k), mi, lb_exp[k]);
        end
        cs_high(1);
        loop_en = 1'b0;
        chk("lb_dv", dv_cnt[1] - base, 6);
        for (int k = 0; k < 6; k++)
            chk($sformatf("lb_rx%0d", k), rx_log[(base + k) % 64], lb_in[k]);

        // Modes 0, 2, 3: A5 out, 3C in
        for (int m = 0; m < 4; m++) begin
            if (m == 1) continue;
            d0 = dv_cnt[m];
            load_tx(m, 8'hA5);
            cs_low(m);
            xfer(m, 8'h3C, 8, mi);
            cs_high(m);
            chk($sformatf("m%0d_rx", m), rx_byte[m], 8'h3C);
            chk($sformatf("m%0d_dv", m), dv_cnt[m] - d0, 1);
            chk($sformatf("m%0d_miso", m), mi, 8'hA5);
        end

        // CS abort after 5 bits (mode 1); holding register still AA from loopback
        d0 = dv_cnt[1];
        cs_low(1);
        xfer(1, 8'hF0, 5, mi);
        cs_high(1);
        chk("ab_dv", dv_cnt[1] - d0, 0);
        chk("ab_miso", miso[1], 1'b1);
        cs_low(1);
        xfer(1, 8'h96, 8, mi);
        cs_high(1);
        chk("ab_rx", rx_byte[1], 8'h96);
        chk("ab_dv2", dv_cnt[1] - d0, 1);
        chk("ab_hold", mi, 8'hAA);

        // Idle: SCK toggling with CS high (mode 0)
        d0 = dv_cnt[0];
        idle_bad = 1'b0;
        for (int k = 0; k < 16; k++) begin
            mosi[0] = k[0];
            sck[0]  = ~sck[0];
            wait_clk(H);
            if (miso[0] !== 1'b1) idle_bad = 1'b1;
        end
        sck[0] = 1'b0;
        wait_clk(H);
        chk("idle_dv", dv_cnt[0] - d0, 0);
        chk("idle_miso", idle_bad, 1'b0);

        // Reset mid-byte (mode 0), then a clean transfer
        load_tx(0, 8'h81);
        cs_low(0);
        xfer(0, 8'hFF, 3, mi);
        i_Rst = 1'b1;
        wait_clk(2);
        chk("mr_dv", rx_dv[0], 1'b0);
        chk("mr_rx", rx_byte[0], 8'h00);
        chk("mr_miso", miso[0], 1'b1);
        cs_n[0] = 1'b1;
        wait_clk(4);
        i_Rst = 1'b0;
        wait_clk(4);
        d0 = dv_cnt[0];
        load_tx(0, 8'h42);
        cs_low(0);
        xfer(0, 8'h7E, 8, mi);
        cs_high(0);
        chk("mr_rx2", rx_byte[0], 8'h7E);
        chk("mr_dv2", dv_cnt[0] - d0, 1);
        chk("mr_miso2", mi, 8'h42);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
